nibble_serial_tx: RTL and testbench

Transmitter for the 4-bit bitwise-logic results (OR/AND/XOR stage outputs) of the lab ALU datapath. It accepts one parallel result word over a valid/ready handshake and latches it. It then shifts the word out on a single serial line as an asynchronous-style frame: one start bit, DATA_W data bits, one stop bit. It is the sending end of the serial result link that the board-level receiver decodes.

---
 rtl/nibble_serial_pkg.sv | 21 ++
 rtl/nibble_serial_tx_bit_timer.sv | 37 +++
 rtl/nibble_serial_tx.sv | 101 ++++++++++
 tb/tb_nibble_serial_tx.sv | 301 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/nibble_serial_pkg.sv
// Shared types and constants for the nibble serial transmitter.
// Line levels are named here so the FSM reads in terms of frame fields.
package nibble_serial_pkg;

   typedef enum logic [1:0] {
      IDLE,
      START,
      DATA,
      STOP
   } tx_state_e;

   localparam logic LINE_IDLE   = 1'b1;
   localparam logic START_LEVEL = 1'b0;
   localparam logic STOP_LEVEL  = 1'b1;

   // Counter width for a modulo-n count; never narrower than one bit.
   function automatic int cnt_width(input int n);
      return (n <= 1) ? 1 : $clog2(n);
   endfunction

endpackage

// File: rtl/nibble_serial_tx_bit_timer.sv
// Bit-period timer: counts 0..CLKS_PER_BIT-1 and flags the last cycle of each bit.
// Held at zero while clear is high so every frame starts on a fresh bit period.
module nibble_serial_tx_bit_timer
   import nibble_serial_pkg::*;
#(
   parameter int CLKS_PER_BIT = 4
) (
   input  logic clk,
   input  logic reset,
   input  logic clear,
   output logic tick
);

   localparam int              CW = cnt_width(CLKS_PER_BIT);
   localparam logic [CW-1:0]   TC = CW'(CLKS_PER_BIT - 1);

   logic [CW-1:0] cnt_q;
   logic [CW-1:0] cnt_d;

   always_comb begin
      cnt_d = cnt_q + 1'b1;
      if (clear || (cnt_q == TC)) begin
         cnt_d = '0;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   assign tick = (cnt_q == TC);

endmodule

// File: rtl/nibble_serial_tx.sv
// Serial transmitter for ALU logic-stage results: start bit, DATA_W data bits, stop bit.
// tx_out comes straight from a flop so the line never glitches between bits.
module nibble_serial_tx
   import nibble_serial_pkg::*;
#(
   parameter int DATA_W       = 4,
   parameter int CLKS_PER_BIT = 4,
   parameter int MSB_FIRST    = 0
) (
   input  logic              clk,
   input  logic              reset,
   input  logic [DATA_W-1:0] data_in,
   input  logic              data_valid,
   output logic              data_ready,
   output logic              tx_out,
   output logic              busy,
   output logic              done
);

   localparam int            IW       = cnt_width(DATA_W);
   localparam logic [IW-1:0] LAST_IDX = IW'(DATA_W - 1);

   tx_state_e         state_q;
   logic              tx_q;
   logic [DATA_W-1:0] sr_q;
   logic [IW-1:0]     idx_q;
   logic              tick;

   // Next bit to put on the line, and the register after it has been consumed.
   function automatic logic head(input logic [DATA_W-1:0] w);
      return (MSB_FIRST != 0) ? w[DATA_W-1] : w[0];
   endfunction

   function automatic logic [DATA_W-1:0] shift(input logic [DATA_W-1:0] w);
      return (MSB_FIRST != 0) ? (w << 1) : (w >> 1);
   endfunction

   nibble_serial_tx_bit_timer #(
      .CLKS_PER_BIT (CLKS_PER_BIT)
   ) u_bit_timer (
      .clk   (clk),
      .reset (reset),
      .clear (state_q == IDLE),
      .tick  (tick)
   );

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= IDLE;
         tx_q    <= LINE_IDLE;
         sr_q    <= '0;
         idx_q   <= '0;
      end else begin
         case (state_q)
            IDLE: begin
               if (data_valid) begin
                  sr_q    <= data_in;
                  tx_q    <= START_LEVEL;
                  state_q <= START;
               end
            end
            START: begin
               if (tick) begin
                  tx_q    <= head(sr_q);
                  sr_q    <= shift(sr_q);
                  idx_q   <= '0;
                  state_q <= DATA;
               end
            end
            DATA: begin
               if (tick) begin
                  if (idx_q == LAST_IDX) begin
                     tx_q    <= STOP_LEVEL;
                     state_q <= STOP;
                  end else begin
                     tx_q  <= head(sr_q);
                     sr_q  <= shift(sr_q);
                     idx_q <= idx_q + 1'b1;
                  end
               end
            end
            STOP: begin
               if (tick) begin
                  state_q <= IDLE;
               end
            end
            default: begin
               state_q <= IDLE;
               tx_q    <= LINE_IDLE;
            end
         endcase
      end
   end

   // A reset landing in the last stop cycle abandons the frame, so done is masked too.
   assign data_ready = (state_q == IDLE) && !reset;
   assign busy       = (state_q != IDLE);
   assign done       = (state_q == STOP) && tick && !reset;
   assign tx_out     = tx_q;

endmodule

// File: tb/tb_nibble_serial_tx.sv
// Self-checking bench for nibble_serial_tx: default, MSB-first and one-clock-per-bit builds.
// Expected line levels come from a frame-slot model of start/data/stop bits.
module tb_nibble_serial_tx;

   logic clk = 1'b0;
   logic reset = 1'b0;
   always #5 clk = ~clk;

   logic [3:0] d_data = '0, m_data = '0, c_data = '0;
   logic d_valid = 1'b0, m_valid = 1'b0, c_valid = 1'b0;
   logic d_ready, d_tx, d_busy, d_done;
   logic m_ready, m_tx, m_busy, m_done;
   logic c_ready, c_tx, c_busy, c_done;

   int n_checks = 0;
   int n_fail   = 0;

   nibble_serial_tx #(.DATA_W(4), .CLKS_PER_BIT(4), .MSB_FIRST(0)) u_dut (
      .clk(clk), .reset(reset), .data_in(d_data), .data_valid(d_valid),
      .data_ready(d_ready), .tx_out(d_tx), .busy(d_busy), .done(d_done));

   nibble_serial_tx #(.DATA_W(4), .CLKS_PER_BIT(4), .MSB_FIRST(1)) u_msb (
      .clk(clk), .reset(reset), .data_in(m_data), .data_valid(m_valid),
      .data_ready(m_ready), .tx_out(m_tx), .busy(m_busy), .done(m_done));

   nibble_serial_tx #(.DATA_W(4), .CLKS_PER_BIT(1), .MSB_FIRST(0)) u_cpb1 (
      .clk(clk), .reset(reset), .data_in(c_data), .data_valid(c_valid),
      .data_ready(c_ready), .tx_out(c_tx), .busy(c_busy), .done(c_done));

   // Line level k cycles after the transfer edge (k = 1 .. 6*cpb).
   function automatic logic exp_line(input logic [3:0] w, input bit msb, input int cpb, input int k);
      int slot;
      slot = (k - 1) / cpb;
      if (slot == 0) return 1'b0;
      if (slot >= 5) return 1'b1;
      return msb ? w[4 - slot] : w[slot - 1];
   endfunction

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      reset = 1'b1;
      step();
      step();
      n_checks++;
      if ({d_tx, d_ready, d_busy, d_done} !== 4'b1000) begin
         n_fail++;
         $display("FAIL reset_state: got tx/ready/busy/done=%b want 1000", {d_tx, d_ready, d_busy, d_done});
      end
      n_checks++;
      if ({m_tx, c_tx, m_busy, c_busy} !== 4'b1100) begin
         n_fail++;
         $display("FAIL reset_other: got m_tx/c_tx/m_busy/c_busy=%b want 1100", {m_tx, c_tx, m_busy, c_busy});
      end
      reset = 1'b0;
      #1;
      n_checks++;
      if ({d_ready, m_ready, c_ready} !== 3'b111) begin
         n_fail++;
         $display("FAIL reset_release_ready: got %b want 111", {d_ready, m_ready, c_ready});
      end
      step();
   endtask

   task automatic test_basic();
      logic [3:0] w;
      w = 4'b1010;
      d_data = w;
      d_valid = 1'b1;
      step();
      d_valid = 1'b0;
      for (int k = 1; k <= 24; k++) begin
         n_checks++;
         if ({d_tx, d_done, d_ready, d_busy} !== {exp_line(w, 1'b0, 4, k), (k == 24), 1'b0, 1'b1}) begin
            n_fail++;
            $display("FAIL basic_frame cyc %0d: got tx/done/ready/busy=%b want %b", k,
                     {d_tx, d_done, d_ready, d_busy}, {exp_line(w, 1'b0, 4, k), (k == 24), 1'b0, 1'b1});
         end
         step();
      end
      n_checks++;
      if ({d_tx, d_done, d_ready, d_busy} !== 4'b1010) begin
         n_fail++;
         $display("FAIL basic_after cyc 25: got tx/done/ready/busy=%b want 1010", {d_tx, d_done, d_ready, d_busy});
      end
      step();
   endtask

   task automatic test_back_to_back();
      logic [3:0] w1, w2;
      w1 = 4'h3;
      w2 = 4'hC;
      d_data = w1;
      d_valid = 1'b1;
      step();
      d_data = w2;
      for (int k = 1; k <= 24; k++) begin
         n_checks++;
         if ({d_tx, d_done} !== {exp_line(w1, 1'b0, 4, k), (k == 24)}) begin
            n_fail++;
            $display("FAIL b2b_first cyc %0d: got tx/done=%b want %b", k, {d_tx, d_done},
                     {exp_line(w1, 1'b0, 4, k), (k == 24)});
         end
         step();
      end
      n_checks++;
      if ({d_tx, d_ready, d_busy} !== 3'b110) begin
         n_fail++;
         $display("FAIL b2b_gap: got tx/ready/busy=%b want 110", {d_tx, d_ready, d_busy});
      end
      step();
      d_valid = 1'b0;
      for (int k = 1; k <= 24; k++) begin
         n_checks++;
         if ({d_tx, d_done} !== {exp_line(w2, 1'b0, 4, k), (k == 24)}) begin
            n_fail++;
            $display("FAIL b2b_second cyc %0d: got tx/done=%b want %b", k, {d_tx, d_done},
                     {exp_line(w2, 1'b0, 4, k), (k == 24)});
         end
         step();
      end
      step();
   endtask

   task automatic test_reset_mid_frame();
      int done_seen;
      d_data = 4'hF;
      d_valid = 1'b1;
      step();
      d_valid = 1'b0;
      for (int k = 1; k < 10; k++) begin
         n_checks++;
         if (d_tx !== exp_line(4'hF, 1'b0, 4, k)) begin
            n_fail++;
            $display("FAIL midrst_pre cyc %0d: got tx=%b want %b", k, d_tx, exp_line(4'hF, 1'b0, 4, k));
         end
         step();
      end
      reset = 1'b1;
      step();
      reset = 1'b0;
      #1;
      n_checks++;
      if ({d_tx, d_busy, d_ready, d_done} !== 4'b1010) begin
         n_fail++;
         $display("FAIL midrst_after: got tx/busy/ready/done=%b want 1010", {d_tx, d_busy, d_ready, d_done});
      end
      done_seen = 0;
      for (int k = 0; k < 30; k++) begin
         if (d_done || !d_tx) done_seen++;
         step();
      end
      n_checks++;
      if (done_seen != 0) begin
         n_fail++;
         $display("FAIL midrst_quiet: got %0d cycles with done or low line, want 0", done_seen);
      end
      d_data = 4'h1;
      d_valid = 1'b1;
      step();
      d_valid = 1'b0;
      for (int k = 1; k <= 24; k++) begin
         n_checks++;
         if ({d_tx, d_done} !== {exp_line(4'h1, 1'b0, 4, k), (k == 24)}) begin
            n_fail++;
            $display("FAIL midrst_resend cyc %0d: got tx/done=%b want %b", k, {d_tx, d_done},
                     {exp_line(4'h1, 1'b0, 4, k), (k == 24)});
         end
         step();
      end
      step();
   endtask

   task automatic test_ignore_busy();
      int extra;
      d_data = 4'h0;
      d_valid = 1'b1;
      step();
      d_valid = 1'b0;
      for (int k = 1; k <= 24; k++) begin
         if (k == 6) begin
            d_data = 4'h9;
            d_valid = 1'b1;
         end else begin
            d_valid = 1'b0;
         end
         n_checks++;
         if ({d_tx, d_done} !== {exp_line(4'h0, 1'b0, 4, k), (k == 24)}) begin
            n_fail++;
            $display("FAIL ignore_frame cyc %0d: got tx/done=%b want %b", k, {d_tx, d_done},
                     {exp_line(4'h0, 1'b0, 4, k), (k == 24)});
         end
         step();
      end
      extra = 0;
      for (int k = 0; k < 30; k++) begin
         if (d_busy || !d_tx) extra++;
         step();
      end
      n_checks++;
      if (extra != 0) begin
         n_fail++;
         $display("FAIL ignore_no_second: got %0d busy cycles, want 0", extra);
      end
   endtask

   task automatic test_msb_first();
      m_data = 4'b1000;
      m_valid = 1'b1;
      step();
      m_valid = 1'b0;
      for (int k = 1; k <= 24; k++) begin
         n_checks++;
         if ({m_tx, m_done} !== {exp_line(4'b1000, 1'b1, 4, k), (k == 24)}) begin
            n_fail++;
            $display("FAIL msb_frame cyc %0d: got tx/done=%b want %b", k, {m_tx, m_done},
                     {exp_line(4'b1000, 1'b1, 4, k), (k == 24)});
         end
         step();
      end
      step();
   endtask

   task automatic test_one_clk_per_bit();
      c_data = 4'b0110;
      c_valid = 1'b1;
      step();
      c_valid = 1'b0;
      for (int k = 1; k <= 6; k++) begin
         n_checks++;
         if ({c_tx, c_done, c_busy} !== {exp_line(4'b0110, 1'b0, 1, k), (k == 6), 1'b1}) begin
            n_fail++;
            $display("FAIL cpb1_frame cyc %0d: got tx/done/busy=%b want %b", k, {c_tx, c_done, c_busy},
                     {exp_line(4'b0110, 1'b0, 1, k), (k == 6), 1'b1});
         end
         step();
      end
      n_checks++;
      if ({c_tx, c_ready, c_busy} !== 3'b110) begin
         n_fail++;
         $display("FAIL cpb1_after: got tx/ready/busy=%b want 110", {c_tx, c_ready, c_busy});
      end
      step();
   endtask

   task automatic test_random();
      logic [3:0] w;
      logic [3:0] wm;
      int gap;
      for (int n = 0; n < 20; n++) begin
         gap = $urandom_range(0, 3);
         d_valid = 1'b0;
         for (int g = 0; g < gap; g++) begin
            n_checks++;
            if ({d_tx, d_busy} !== 2'b10) begin
               n_fail++;
               $display("FAIL rand_idle word %0d: got tx/busy=%b want 10", n, {d_tx, d_busy});
            end
            step();
         end
         w = 4'($urandom);
         wm = 4'($urandom);
         d_data = w;
         d_valid = 1'b1;
         m_data = wm;
         m_valid = 1'b1;
         step();
         m_valid = 1'b0;
         for (int k = 1; k <= 24; k++) begin
            d_valid = 1'($urandom);
            d_data = 4'($urandom);
            n_checks++;
            if ({d_tx, d_done, m_tx} !== {exp_line(w, 1'b0, 4, k), (k == 24), exp_line(wm, 1'b1, 4, k)}) begin
               n_fail++;
               $display("FAIL rand_frame word %0d cyc %0d: got tx/done/mtx=%b want %b", n, k,
                        {d_tx, d_done, m_tx}, {exp_line(w, 1'b0, 4, k), (k == 24), exp_line(wm, 1'b1, 4, k)});
            end
            step();
         end
      end
      d_valid = 1'b0;
      step();
   endtask

   initial begin
      test_reset();
      test_basic();
      test_back_to_back();
      test_reset_mid_frame();
      test_ignore_busy();
      test_msb_first();
      test_one_clk_per_bit();
      test_random();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
